// File: rtl/regfile_write_arbiter.sv
// regfile_write_arbiter: round-robin scheduler mapping up to NUM_REQ write requests onto NUM_WPORTS register-file write ports
module regfile_write_arbiter #(
    parameter int NUM_REQ    = 6,
    parameter int NUM_WPORTS = 4,
    parameter int ADDR_W     = 7,
    parameter int DATA_W     = 65
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic [NUM_REQ-1:0]           req_valid,
    input  logic [NUM_REQ*ADDR_W-1:0]    req_addr,
    input  logic [NUM_REQ*DATA_W-1:0]    req_data,
    output logic [NUM_REQ-1:0]           req_ready,
    output logic [NUM_WPORTS-1:0]        wr_en,
    output logic [NUM_WPORTS*ADDR_W-1:0] wr_addr,
    output logic [NUM_WPORTS*DATA_W-1:0] wr_data,
    output logic [2:0]                   rr_ptr,
    output logic [15:0]                  conflict_cnt,
    output logic [15:0]                  portfull_cnt
);
    localparam int CW = $clog2(NUM_WPORTS + 1);

    logic [CW-1:0]     n;
    logic [2:0]        last;
    logic [NUM_REQ-1:0] grant;
    logic              conflict;
    logic              full;
    logic [3:0]        sum;
    logic [2:0]        idx;
    logic [ADDR_W-1:0] a;
    logic              hit;
    logic [ADDR_W-1:0] gaddr [NUM_WPORTS];
    logic [2:0]        gsel  [NUM_WPORTS];

    // Scan from rr_ptr; the n-th grant lands on write port n
    always_comb begin
        grant    = '0;
        n        = '0;
        conflict = 1'b0;
        full     = 1'b0;
        last     = rr_ptr;
        sum      = '0;
        idx      = '0;
        a        = '0;
        hit      = 1'b0;
        for (int k = 0; k < NUM_WPORTS; k++) begin
            gaddr[k] = '0;
            gsel[k]  = '0;
        end
        for (int s = 0; s < NUM_REQ; s++) begin
            sum = {1'b0, rr_ptr} + 4'(s);
            idx = sum >= 4'(NUM_REQ) ? 3'(sum - 4'(NUM_REQ)) : sum[2:0];
            a   = req_addr[idx*ADDR_W +: ADDR_W];
            hit = 1'b0;
            for (int k = 0; k < NUM_WPORTS; k++)
                if (CW'(k) < n && gaddr[k] == a) hit = 1'b1;
            if (req_valid[idx]) begin
                if (hit) conflict = 1'b1;
                else if (n == CW'(NUM_WPORTS)) full = 1'b1;
                else begin
                    for (int k = 0; k < NUM_WPORTS; k++)
                        if (CW'(k) == n) begin
                            gaddr[k] = a;
                            gsel[k]  = idx;
                        end
                    grant[idx] = 1'b1;
                    n          = n + CW'(1);
                    last       = idx;
                end
            end
        end
    end

    assign req_ready = reset ? '0 : grant;

    always_ff @(posedge clock) begin
        if (reset) begin
            wr_en        <= '0;
            wr_addr      <= '0;
            wr_data      <= '0;
            rr_ptr       <= '0;
            conflict_cnt <= '0;
            portfull_cnt <= '0;
        end else begin
            for (int k = 0; k < NUM_WPORTS; k++) begin
                wr_en[k] <= CW'(k) < n;
                if (CW'(k) < n) begin
                    wr_addr[k*ADDR_W +: ADDR_W] <= gaddr[k];
                    wr_data[k*DATA_W +: DATA_W] <= req_data[gsel[k]*DATA_W +: DATA_W];
                end
            end
            if (n != '0) rr_ptr <= last == 3'(NUM_REQ - 1) ? 3'd0 : last + 3'd1;
            if (conflict && conflict_cnt != 16'hffff) conflict_cnt <= conflict_cnt + 16'd1;
            if (full && portfull_cnt != 16'hffff) portfull_cnt <= portfull_cnt + 16'd1;
        end
    end
endmodule

// File: tb/tb_regfile_write_arbiter.sv
// tb_regfile_write_arbiter: directed vectors with hand-computed expectations for regfile_write_arbiter
module tb_regfile_write_arbiter;
    logic          clock = 1'b0;
    logic          reset;
    logic [5:0]    req_valid;
    logic [41:0]   req_addr;
    logic [389:0]  req_data;
    logic [5:0]    req_ready;
    logic [3:0]    wr_en;
    logic [27:0]   wr_addr;
    logic [259:0]  wr_data;
    logic [2:0]    rr_ptr;
    logic [15:0]   conflict_cnt;
    logic [15:0]   portfull_cnt;
    int            total = 0;
    int            bad = 0;

    regfile_write_arbiter dut (
        .clock(clock), .reset(reset),
        .req_valid(req_valid), .req_addr(req_addr), .req_data(req_data), .req_ready(req_ready),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .rr_ptr(rr_ptr), .conflict_cnt(conflict_cnt), .portfull_cnt(portfull_cnt)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [79:0] got, input logic [79:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [64:0] dat(input int i);
        return {1'b1, 64'(i + 1) * 64'h1111};
    endfunction

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic set_addrs(input logic [6:0] a0, a1, a2, a3, a4, a5);
        req_addr = {a5, a4, a3, a2, a1, a0};
    endtask

    function automatic logic [6:0] pa(input int k);
        return wr_addr[k*7 +: 7];
    endfunction

    function automatic logic [64:0] pd(input int k);
        return wr_data[k*65 +: 65];
    endfunction

    initial begin
        reset = 1'b1;
        req_valid = 6'h3f;
        set_addrs(7'h10, 7'h11, 7'h12, 7'h13, 7'h14, 7'h15);
        for (int i = 0; i < 6; i++) req_data[i*65 +: 65] = dat(i);
        tick();
        tick();
        chk("ready_in_reset", 80'(req_ready), 80'h0);
        chk("rst_wr_en", 80'(wr_en), 80'h0);
        chk("rst_wr_addr", 80'(wr_addr), 80'h0);
        chk("rst_rr_ptr", 80'(rr_ptr), 80'h0);
        chk("rst_conflict", 80'(conflict_cnt), 80'h0);
        chk("rst_portfull", 80'(portfull_cnt), 80'h0);
        reset = 1'b0;
        req_valid = 6'h00;
        #1;
        chk("idle_ready", 80'(req_ready), 80'h0);
        tick();
        chk("idle_wr_en", 80'(wr_en), 80'h0);
        chk("idle_rr_ptr", 80'(rr_ptr), 80'h0);

        // full load: six distinct addresses, four ports
        req_valid = 6'h3f;
        #1;
        chk("full_ready0", 80'(req_ready), 80'h0f);
        tick();
        chk("full_wr_en0", 80'(wr_en), 80'hf);
        for (int k = 0; k < 4; k++) begin
            chk("full_addr", 80'(pa(k)), 80'(7'h10 + 7'(k)));
            chk("full_data", 80'(pd(k)), 80'(dat(k)));
        end
        chk("full_rr_ptr", 80'(rr_ptr), 80'h4);
        chk("full_portfull", 80'(portfull_cnt), 80'h1);
        chk("full_conflict", 80'(conflict_cnt), 80'h0);
        req_valid = 6'h30;
        #1;
        chk("full_ready1", 80'(req_ready), 80'h30);
        tick();
        chk("full_wr_en1", 80'(wr_en), 80'h3);
        chk("full_p0_addr", 80'(pa(0)), 80'h14);
        chk("full_p1_addr", 80'(pa(1)), 80'h15);
        chk("full_p1_data", 80'(pd(1)), 80'(dat(5)));
        chk("hold_p2_addr", 80'(pa(2)), 80'h12);
        chk("hold_p3_data", 80'(pd(3)), 80'(dat(3)));
        chk("full_rr_wrap", 80'(rr_ptr), 80'h0);
        chk("full_portfull1", 80'(portfull_cnt), 80'h1);
        req_valid = 6'h00;
        tick();
        chk("idle2_wr_en", 80'(wr_en), 80'h0);
        chk("idle2_rr_ptr", 80'(rr_ptr), 80'h0);

        // address conflict between requesters 0 and 2
        set_addrs(7'h11, 7'h20, 7'h11, 7'h21, 7'h22, 7'h23);
        req_valid = 6'b000101;
        #1;
        chk("conf_ready0", 80'(req_ready), 80'h01);
        tick();
        chk("conf_wr_en0", 80'(wr_en), 80'h1);
        chk("conf_p0_data", 80'(pd(0)), 80'(dat(0)));
        chk("conf_cnt", 80'(conflict_cnt), 80'h1);
        chk("conf_rr_ptr", 80'(rr_ptr), 80'h1);
        req_valid = 6'b000100;
        #1;
        chk("conf_ready1", 80'(req_ready), 80'h04);
        tick();
        chk("conf_wr_en1", 80'(wr_en), 80'h1);
        chk("conf_p0_addr", 80'(pa(0)), 80'h11);
        chk("conf_p0_data2", 80'(pd(0)), 80'(dat(2)));
        chk("conf_rr_ptr2", 80'(rr_ptr), 80'h3);
        chk("conf_cnt_hold", 80'(conflict_cnt), 80'h1);

        // wrap-around: walk rr_ptr to 5, then requesters 5 and 0
        req_valid = 6'b010000;
        tick();
        chk("wrap_pre_rr", 80'(rr_ptr), 80'h5);
        req_valid = 6'b100001;
        #1;
        chk("wrap_ready", 80'(req_ready), 80'h21);
        tick();
        chk("wrap_wr_en", 80'(wr_en), 80'h3);
        chk("wrap_p0_addr", 80'(pa(0)), 80'h23);
        chk("wrap_p1_addr", 80'(pa(1)), 80'h11);
        chk("wrap_p0_data", 80'(pd(0)), 80'(dat(5)));
        chk("wrap_rr_ptr", 80'(rr_ptr), 80'h1);
        req_valid = 6'h00;
        tick();

        // reset in the middle of a six-request burst
        set_addrs(7'h30, 7'h31, 7'h32, 7'h33, 7'h34, 7'h35);
        req_valid = 6'h3f;
        #1;
        chk("burst_ready", 80'(req_ready), 80'h1e);
        tick();
        reset = 1'b1;
        #1;
        chk("burst_ready_rst", 80'(req_ready), 80'h0);
        chk("burst_emitted", 80'(wr_en), 80'hf);
        chk("burst_p0_addr", 80'(pa(0)), 80'h31);
        tick();
        chk("mrst_wr_en", 80'(wr_en), 80'h0);
        chk("mrst_rr_ptr", 80'(rr_ptr), 80'h0);
        chk("mrst_conflict", 80'(conflict_cnt), 80'h0);
        chk("mrst_portfull", 80'(portfull_cnt), 80'h0);
        reset = 1'b0;
        #1;
        chk("mrst_ready", 80'(req_ready), 80'h0f);
        tick();
        chk("mrst_wr_en1", 80'(wr_en), 80'hf);
        chk("mrst_p0_addr", 80'(pa(0)), 80'h30);
        chk("mrst_rr_ptr1", 80'(rr_ptr), 80'h4);
        chk("mrst_portfull1", 80'(portfull_cnt), 80'h1);
        req_valid = 6'h00;
        tick();

        // permanent conflict long enough to saturate the counter
        set_addrs(7'h22, 7'h22, 7'h00, 7'h00, 7'h00, 7'h00);
        req_valid = 6'b000011;
        for (int i = 0; i < 70000; i++) tick();
        chk("sat_conflict", 80'(conflict_cnt), 80'hffff);
        chk("sat_portfull", 80'(portfull_cnt), 80'h1);
        req_valid = 6'b000010;
        #1;
        chk("sat_ready", 80'(req_ready), 80'h02);
        tick();
        chk("sat_wr_en", 80'(wr_en), 80'h1);
        chk("sat_p0_data", 80'(pd(0)), 80'(dat(1)));
        chk("sat_conflict_hold", 80'(conflict_cnt), 80'hffff);
        req_valid = 6'h00;
        tick();
        chk("end_wr_en", 80'(wr_en), 80'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/regfile_write_arbiter.md
# regfile_write_arbiter

Write-port scheduler for the 128-entry × 65-bit multi-ported register file. It accepts up to NUM_REQ independent write requests per cycle over valid/ready handshakes. Each cycle it grants at most NUM_WPORTS of them in round-robin priority order, never granting two writes to the same address in one cycle. It drives the file's write ports from registered outputs. It sits between the execution/writeback units and the register-file macro and owns all write-port sequencing.

## Interface
- NUM_REQ, 6, number of write requesters.
- NUM_WPORTS, 4, number of register-file write ports driven.
- ADDR_W, 7, write address width.
- DATA_W, 65, write data width.

- clock  input  1  single clock; all state updates on its rising edge.
- reset  input  1  synchronous, active-high reset.
- req_valid  input  NUM_REQ  request i present.
- req_addr  input  NUM_REQ*ADDR_W  address of request i; slice i is bits [i*ADDR_W +: ADDR_W].
- req_data  input  NUM_REQ*DATA_W  data of request i; slice i is bits [i*DATA_W +: DATA_W].
- req_ready  output  NUM_REQ  request i accepted this cycle; combinational.
- wr_en  output  NUM_WPORTS  write-port k enable; registered.
- wr_addr  output  NUM_WPORTS*ADDR_W  write-port k address; registered.
- wr_data  output  NUM_WPORTS*DATA_W  write-port k data; registered.
- rr_ptr  output  3  current highest-priority requester index; debug.
- conflict_cnt  output  16  saturating count of cycles with at least one address-conflict denial.
- portfull_cnt  output  16  saturating count of cycles with at least one port-exhaustion denial.

## Operation
- Transfer for requester i occurs when req_valid[i] && req_ready[i].
- req_ready[i] depends only on the current req_valid, req_addr and rr_ptr. It never depends on req_data.
- Grant scan:
  - Visit requesters in the order rr_ptr, rr_ptr+1, …, wrapping mod NUM_REQ, for NUM_REQ steps.
  - Grant requester i when all three hold: it is valid; fewer than NUM_WPORTS grants have been made so far this cycle; its addr differs from every address already granted this cycle.
- Denial reasons:
  - A valid requester whose address equals an earlier grant's address is denied for address conflict.
  - Otherwise, a valid requester denied because all ports are taken is denied for port exhaustion.
  - Address conflict takes precedence when both apply.
- Port assignment: the n-th grant in scan order (n = 0…) goes to write port n. Ports beyond the grant count have wr_en = 0 next cycle.
- Pointer update:
  - With at least one grant, rr_ptr <= (index of last granted requester + 1) mod NUM_REQ.
  - With no grants, rr_ptr holds.
- Counters:
  - conflict_cnt increments by 1 in any cycle with at least one address-conflict denial.
  - portfull_cnt increments by 1 in any cycle with at least one port-exhaustion denial.
  - Each counter increments at most once per cycle and saturates at 0xFFFF.
- Ungranted requesters keep req_valid asserted and must hold addr/data stable; there is no internal buffering.
- Granted write ports never share an address in the same cycle, so port ordering inside the register file is irrelevant.

## Timing
- Latency: an accepted request appears on wr_en/wr_addr/wr_data exactly one cycle after the handshake cycle. The register file commits it on that following edge.
- Throughput: up to NUM_WPORTS writes per cycle, sustained.
- wr_addr/wr_data of disabled ports hold their previous value.
- Reset (synchronous, takes effect at the edge where reset = 1), reset values:
  - wr_en = 0.
  - wr_addr = 0.
  - wr_data = 0.
  - rr_ptr = 0.
  - conflict_cnt = 0.
  - portfull_cnt = 0.
- While reset is high:
  - req_ready = 0; no transfers occur.
  - A request accepted in the cycle before reset asserts is still emitted if that edge is not a reset edge. Otherwise it is dropped and wr_en = 0.
- No valid requests: all req_ready = 0, wr_en = 0 next cycle, counters and rr_ptr unchanged.

## Test plan
- Reset then idle: after 2 reset cycles, check wr_en = 0, rr_ptr = 0, both counters = 0, req_ready = 0.
- Full load, distinct addrs 0x10–0x15 on requesters 0–5, rr_ptr = 0:
  - Cycle 0: ready = 0b001111.
  - Cycle 1: ports 0–3 show 0x10–0x13, rr_ptr = 4, portfull_cnt = 1.
  - Requesters 4 and 5 are granted in cycle 1 on ports 0 and 1.
- Address conflict, req0 and req2 both addr 0x11, rr_ptr = 0:
  - ready = 0b000001; next cycle port 0 = req0 data and wr_en = 0b0001.
  - conflict_cnt = 1, rr_ptr = 1.
  - Following cycle: req2 granted on port 0.
- Wrap-around: force rr_ptr = 5 via prior traffic, then req5 and req0 valid. Port 0 = req5, port 1 = req0, rr_ptr becomes 1.
- Reset mid-burst: assert reset while 6 requests are pending. Check no wr_en the next cycle, rr_ptr = 0, counters = 0, and scheduling restarts from requester 0.
- Saturation: hold a permanent conflict for 70000 cycles. conflict_cnt must stick at 0xFFFF, and the denied requester is granted once its competitor drops.
